// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-retire stage.
// Write-data source encodings and the occupancy counter width.
package wb_pkg;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lane: youngest-first search over the retire buffer.
// Walks oldest to youngest from head so the last match (youngest) wins.
module wb_fwd_match #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]           query,
    input  logic [DEPTH-1:0]        valid,
    input  logic [PW-1:0]           head,
    input  logic [DEPTH*AW-1:0]     ent_a3,
    input  logic [DEPTH*DATA_W-1:0] ent_wd,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (query != '0 && valid[idx] &&
                ent_a3[idx*AW +: AW] == query) begin
                hit  = 1'b1;
                data = ent_wd[idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/wb_retire_buffer.sv
// Writeback-retire stage: selects write data, queues it in a circular
// buffer, drains to a shared GRF port and forwards buffered results.
module wb_retire_buffer import wb_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int AW      = 5,
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 2,
    localparam int CW     = cnt_w(DEPTH),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic                      In_Flush,
    input  logic                      In_RFWr,
    input  logic [AW-1:0]             In_A3,
    input  logic [1:0]                In_WDSel,
    input  logic [DATA_W-1:0]         In_Y,
    input  logic [DATA_W-1:0]         In_DR,
    input  logic [DATA_W-1:0]         In_PC,
    output logic                      GRF_We,
    output logic [AW-1:0]             GRF_A3,
    output logic [DATA_W-1:0]         GRF_WD,
    input  logic                      GRF_Ready,
    input  logic [NUM_FWD*AW-1:0]     Fwd_A,
    output logic [NUM_FWD-1:0]        Fwd_Hit,
    output logic [NUM_FWD*DATA_W-1:0] Fwd_Data,
    output logic [CW-1:0]             Count
);

    logic [DEPTH*AW-1:0]     a3_q;
    logic [DEPTH*DATA_W-1:0] wd_q;
    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [DATA_W-1:0]       wdata;
    logic [DEPTH-1:0]        valid;
    logic                    fire;
    logic                    alloc;
    logic                    retire;

    always_comb begin
        wdata = In_Y;
        unique case (In_WDSel)
            WD_DM:   wdata = In_DR;
            WD_PC8:  wdata = In_PC + DATA_W'(8);
            default: wdata = In_Y;
        endcase
    end

    // A full buffer still accepts when the head retires on this edge.
    assign In_Ready = (Count != CW'(DEPTH)) | GRF_Ready;
    assign fire     = In_Valid & In_Ready & ~In_Flush;
    assign alloc    = fire & In_RFWr & (In_A3 != '0);

    assign GRF_We = (Count != '0);
    assign GRF_A3 = a3_q[head_q*AW +: AW];
    assign GRF_WD = wd_q[head_q*DATA_W +: DATA_W];
    assign retire = GRF_We & GRF_Ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = {1'b0, PW'(i) - head_q} < Count;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a3_q   <= '0;
            wd_q   <= '0;
            head_q <= '0;
            tail_q <= '0;
            Count  <= '0;
        end else begin
            if (alloc) begin
                a3_q[tail_q*AW +: AW]         <= In_A3;
                wd_q[tail_q*DATA_W +: DATA_W] <= wdata;
                tail_q                        <= tail_q + 1'b1;
            end
            if (retire) begin
                head_q <= head_q + 1'b1;
            end
            case ({alloc, retire})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
        wb_fwd_match #(
            .DATA_W(DATA_W),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_match (
            .query (Fwd_A[g*AW +: AW]),
            .valid (valid),
            .head  (head_q),
            .ent_a3(a3_q),
            .ent_wd(wd_q),
            .hit   (Fwd_Hit[g]),
            .data  (Fwd_Data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed self-checking bench for wb_retire_buffer.
// Retires are logged from the GRF port and compared with an expected list.
module tb_wb_retire_buffer;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        In_Valid, In_Ready, In_Flush, In_RFWr;
    logic [4:0]  In_A3;
    logic [1:0]  In_WDSel;
    logic [31:0] In_Y, In_DR, In_PC;
    logic        GRF_We, GRF_Ready;
    logic [4:0]  GRF_A3;
    logic [31:0] GRF_WD;
    logic [9:0]  Fwd_A;
    logic [1:0]  Fwd_Hit;
    logic [63:0] Fwd_Data;
    logic [2:0]  Count;

    int checks = 0;
    int failures = 0;
    logic [36:0] obs_q[$];
    logic [36:0] exp_q[$];

    always #5 Clk = ~Clk;

    wb_retire_buffer dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Flush(In_Flush),
        .In_RFWr(In_RFWr), .In_A3(In_A3), .In_WDSel(In_WDSel),
        .In_Y(In_Y), .In_DR(In_DR), .In_PC(In_PC),
        .GRF_We(GRF_We), .GRF_A3(GRF_A3), .GRF_WD(GRF_WD),
        .GRF_Ready(GRF_Ready),
        .Fwd_A(Fwd_A), .Fwd_Hit(Fwd_Hit), .Fwd_Data(Fwd_Data),
        .Count(Count)
    );

    // Inputs only change just after posedge, so negedge sees edge values.
    always @(negedge Clk) begin
        if (Rst_n && GRF_We && GRF_Ready) obs_q.push_back({GRF_A3, GRF_WD});
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic [4:0] a3, input logic [1:0] sel,
                       input logic [31:0] y, input logic [31:0] dr,
                       input logic [31:0] pc);
        In_Valid = 1'b1; In_RFWr = 1'b1; In_Flush = 1'b0;
        In_A3 = a3; In_WDSel = sel; In_Y = y; In_DR = dr; In_PC = pc;
    endtask

    task automatic idle();
        In_Valid = 1'b0; In_RFWr = 1'b0; In_Flush = 1'b0; In_A3 = '0;
    endtask

    task automatic cmp_retires(input string tag);
        check({tag, "_n"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int acc, budget, maxc, sent;
        Rst_n = 1'b0; GRF_Ready = 1'b0; Fwd_A = '0;
        In_WDSel = '0; In_Y = '0; In_DR = '0; In_PC = '0;
        idle();
        #12;
        check("rst_count", 64'(Count), 0);
        check("rst_we", 64'(GRF_We), 0);
        check("rst_hit", 64'(Fwd_Hit), 0);
        check("rst_fdata", Fwd_Data, 0);
        check("rst_ready", 64'(In_Ready), 1);
        Rst_n = 1'b1;
        step();

        // single PC+8 request
        GRF_Ready = 1'b1;
        req(5'd8, 2'd2, 32'h0, 32'h0, 32'h3000);
        step();
        idle();
        check("single_we", 64'(GRF_We), 1);
        check("single_a3", 64'(GRF_A3), 8);
        check("single_wd", 64'(GRF_WD), 64'h3008);
        check("single_cnt1", 64'(Count), 1);
        step();
        check("single_we0", 64'(GRF_We), 0);
        check("single_cnt0", 64'(Count), 0);
        exp_q.push_back({5'd8, 32'h3008});
        cmp_retires("single_ret");

        // filtering
        req(5'd0, 2'd0, 32'h55, 32'h0, 32'h0);
        step();
        check("flt_a3zero_cnt", 64'(Count), 0);
        req(5'd5, 2'd0, 32'h55, 32'h0, 32'h0);
        In_RFWr = 1'b0;
        step();
        check("flt_nowr_cnt", 64'(Count), 0);
        req(5'd5, 2'd0, 32'h55, 32'h0, 32'h0);
        In_Flush = 1'b1;
        #1;
        check("flt_flush_ready", 64'(In_Ready), 1);
        step();
        idle();
        check("flt_flush_cnt", 64'(Count), 0);
        check("flt_we", 64'(GRF_We), 0);
        step();
        cmp_retires("flt_ret");

        // back-pressure
        GRF_Ready = 1'b0;
        req(5'd1, 2'd0, 32'h101, 32'h201, 32'h100); step();
        req(5'd2, 2'd1, 32'h102, 32'h202, 32'h200); step();
        req(5'd3, 2'd3, 32'h103, 32'h203, 32'h300); step();
        req(5'd4, 2'd2, 32'h104, 32'h204, 32'h400); step();
        check("bp_cnt4", 64'(Count), 4);
        req(5'd5, 2'd0, 32'h105, 32'h205, 32'h500);
        #1;
        check("bp_ready0", 64'(In_Ready), 0);
        step();
        check("bp_hold_cnt", 64'(Count), 4);
        GRF_Ready = 1'b1;
        #1;
        check("bp_ready1", 64'(In_Ready), 1);
        step();
        idle();
        check("bp_swap_cnt", 64'(Count), 4);
        repeat (4) step();
        check("bp_drain_cnt", 64'(Count), 0);
        exp_q.push_back({5'd1, 32'h101});
        exp_q.push_back({5'd2, 32'h202});
        exp_q.push_back({5'd3, 32'h103});
        exp_q.push_back({5'd4, 32'h408});
        exp_q.push_back({5'd5, 32'h105});
        cmp_retires("bp_ret");

        // forwarding
        GRF_Ready = 1'b0;
        req(5'd5, 2'd0, 32'h11, 32'h0, 32'h0); step();
        req(5'd5, 2'd0, 32'h22, 32'h0, 32'h0); step();
        req(5'd7, 2'd0, 32'h33, 32'h0, 32'h0); step();
        idle();
        Fwd_A = {5'd0, 5'd5};
        #1;
        check("fwd_hit_r5_r0", 64'(Fwd_Hit), 64'b01);
        check("fwd_data_r5", 64'(Fwd_Data[31:0]), 64'h22);
        check("fwd_data_r0", 64'(Fwd_Data[63:32]), 0);
        Fwd_A = {5'd7, 5'd6};
        #1;
        check("fwd_hit_r6_r7", 64'(Fwd_Hit), 64'b10);
        check("fwd_data_r6", 64'(Fwd_Data[31:0]), 0);
        check("fwd_data_r7", 64'(Fwd_Data[63:32]), 64'h33);
        Fwd_A = {5'd0, 5'd5};
        GRF_Ready = 1'b1;
        #1;
        check("fwd_retiring_r5", 64'(Fwd_Data[31:0]), 64'h22);
        repeat (3) step();
        #1;
        check("fwd_empty_hit", 64'(Fwd_Hit), 0);
        Fwd_A = '0;
        exp_q.push_back({5'd5, 32'h11});
        exp_q.push_back({5'd5, 32'h22});
        exp_q.push_back({5'd7, 32'h33});
        cmp_retires("fwd_ret");

        // pointer wrap with toggling grant
        sent = 0; maxc = 0; budget = 0;
        GRF_Ready = 1'b0;
        while (sent < 13 && budget < 200) begin
            logic [4:0]  a;
            logic [31:0] y;
            a = 5'((sent % 31) + 1);
            y = 32'h1000 + 32'(sent);
            if (sent == 0) req(a, 2'd2, y, 32'h0, 32'hFFFF_FFFC);
            else req(a, 2'd0, y, 32'h0, 32'h0);
            #1;
            acc = int'(In_Ready);
            step();
            GRF_Ready = ~GRF_Ready;
            if (int'(Count) > maxc) maxc = int'(Count);
            if (acc != 0) sent++;
            budget++;
        end
        idle();
        check("wrap_budget", 64'(sent), 13);
        GRF_Ready = 1'b1;
        budget = 0;
        while (Count != 0 && budget < 20) begin
            step();
            budget++;
        end
        check("wrap_drain", 64'(Count), 0);
        check("wrap_maxcnt", 64'(maxc), 4);
        for (int i = 0; i < 13; i++)
            exp_q.push_back({5'((i % 31) + 1),
                             (i == 0) ? 32'h4 : 32'h1000 + 32'(i)});
        cmp_retires("wrap_ret");

        // reset mid-flight
        GRF_Ready = 1'b0;
        req(5'd9, 2'd0, 32'h91, 32'h0, 32'h0); step();
        req(5'd10, 2'd0, 32'h92, 32'h0, 32'h0); step();
        req(5'd11, 2'd0, 32'h93, 32'h0, 32'h0); step();
        idle();
        check("mid_cnt3", 64'(Count), 3);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 64'(Count), 0);
        check("mid_rst_we", 64'(GRF_We), 0);
        GRF_Ready = 1'b1;
        step();
        Rst_n = 1'b1;
        repeat (3) step();
        check("mid_after_we", 64'(GRF_We), 0);
        cmp_retires("mid_ret");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_retire_buffer.md
# wb_retire_buffer

Parametrised writeback-retire stage between the memory-stage pipeline register and the GRF write port. Accepts one decoded writeback request per cycle, selects write data, and queues it in a DEPTH-entry circular buffer. Drains one entry per cycle to a shared GRF write port that may be withheld by another writer. Answers NUM_FWD combinational forwarding queries against all buffered, not-yet-retired results.

## Interface
- DATA_W, 32: data and PC width
- AW, 5: register-address width
- DEPTH, 4: buffer entries; power of two, at least 2
- NUM_FWD, 2: number of forwarding query ports
- Clk, in, 1: clock; all state updates on the rising edge
- Rst_n, in, 1: asynchronous, active-low reset
- In_Valid, in, 1: request present
- In_Ready, out, 1: request accepted this cycle when high together with In_Valid
- In_Flush, in, 1: drop this cycle's request; buffered entries are not affected
- In_RFWr, in, 1: request writes the GRF
- In_A3, in, AW: destination register
- In_WDSel, in, 2: data source; 0 ALU, 1 DM, 2 PC+8, 3 ALU
- In_Y, In_DR, In_PC, in, DATA_W each: ALU result, load data, instruction PC
- GRF_We, out, 1: oldest entry presented to the GRF
- GRF_A3, out, AW and GRF_WD, out, DATA_W: oldest entry's address and data
- GRF_Ready, in, 1: port granted; entry retires on this edge when high together with GRF_We
- Fwd_A, in, NUM_FWD*AW: query addresses; lane i is at bits [i*AW +: AW]
- Fwd_Hit, out, NUM_FWD: lane i matched a buffered entry
- Fwd_Data, out, NUM_FWD*DATA_W: matched data; 0 when there is no hit
- Count, out, clog2(DEPTH)+1: occupancy

## Operation
- Write-data select at enqueue:
  - WDSel 0 or 3 selects Y.
  - WDSel 1 selects DR.
  - WDSel 2 selects PC+8, truncated to DATA_W (wraps modulo 2^DATA_W).
  - Only the address and selected data are stored.
- Enqueue fires when In_Valid, In_Ready and !In_Flush are all high.
  - A slot is allocated only if In_RFWr=1 and In_A3 != 0.
  - Otherwise the request is consumed with no slot, no write and no Count change.
- In_Ready = (Count < DEPTH) | GRF_Ready.
  - When full, a simultaneous retire frees the slot in the same cycle.
- In_Flush=1: the request is consumed and discarded, and In_Ready behaves as normal.
- Retire:
  - GRF_We = (Count != 0). GRF_A3 and GRF_WD come from the head entry.
  - The head pointer advances on GRF_Ready & GRF_We.
- Pointers wrap modulo DEPTH.
- Count rule:
  - +1 on allocate only.
  - -1 on retire only.
  - Unchanged when both happen.
- Forwarding, per lane:
  - Fwd_A == 0 never hits.
  - Otherwise all valid entries are searched, including the head that is retiring this cycle.
  - The youngest match wins.
  - The incoming request is not searched; upstream forwards it.
- Entries are strictly FIFO and are never reordered or merged.

## Timing
- Reset (async assert, sync release) sets:
  - Count=0 and both pointers 0
  - GRF_We=0, Fwd_Hit=0, Fwd_Data=0
  - In_Ready=1
- Enqueue-to-GRF write latency: 1 cycle minimum. An entry accepted at edge n is presented in cycle n+1 and retires at edge n+1 if granted. There is no same-cycle bypass to the GRF.
- Combinational outputs:
  - In_Ready depends on Count and GRF_Ready.
  - Fwd_Hit and Fwd_Data depend on Fwd_A and storage only.
- Full, GRF_Ready=0: In_Ready=0 and the request is held upstream.
- Full, GRF_Ready=1: accept and retire in the same edge; Count stays DEPTH.
- Empty, GRF_Ready=1: nothing retires and GRF_We=0.
- Rst_n asserted mid-operation discards all entries immediately; no GRF write is issued.

## Structure
- Shared package wb_pkg holds:
  - the WDSel encodings (WD_ALU=0, WD_DM=1, WD_PC8=2)
  - the Count width function
- One sub-module, wb_fwd_match, is natural. It is instantiated per lane and does a youngest-first priority search over DEPTH entries. Inputs are the valid mask, head pointer and entry array; outputs are hit and data.
- Storage is flat registers, not RAM, because forwarding reads every entry combinationally.

## Test plan
- Reset then single request (A3=8, WDSel=2, PC=0x3000, GRF_Ready=1): GRF_We for exactly one cycle with A3=8, WD=0x3008; Count returns to 0.
- Filtering: requests with A3=0, RFWr=0, or In_Flush=1 → no slot allocated, Count stays 0, GRF_We stays 0.
- Back-pressure, DEPTH=4, GRF_Ready=0, five requests:
  - After the 4th: Count=4 and In_Ready=0.
  - Then GRF_Ready=1: the 5th is accepted in the same cycle as the first retire.
  - Retire order matches enqueue order.
- Forwarding:
  - Buffer holds r5=0x11 (older) and r5=0x22 (younger).
  - Query r5 → Hit=1, Data=0x22.
  - Query r0 → Hit=0, Data=0.
  - Query r6 → Hit=0.
- Pointer wrap: 3·DEPTH+1 back-to-back requests with GRF_Ready toggling every cycle → every entry retires exactly once, in order; Count never exceeds DEPTH.
- Reset mid-flight with Count=3: Count is 0 and GRF_We is 0 immediately on Rst_n low; no GRF write is observed afterwards.
